// File: rtl/inv_mix_columns_seq.sv
// Column-serial AES InvMixColumns engine: accepts a 128-bit state, transforms
// COLS_PER_CYCLE columns per clock in place, then holds the result for the consumer.
module inv_mix_columns_seq #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out
);

  generate
    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : gen_bad_param
      $error("inv_mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST_CNT = 2'(4 - COLS_PER_CYCLE);

  logic [1:0]   r_state;
  logic [1:0]   r_cnt;
  logic [127:0] r_buf;

  logic [127:0] w_next_buf;
  logic [1:0]   w_idx;
  logic         w_last;
  logic         w_accept;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // Multipliers 09/0b/0d/0e are composed from the 2x/4x/8x xtime chain.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a  [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int r = 0; r < 4; r++) begin
      a[r]  = col[31-8*r -: 8];
      x2    = xtime(a[r]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[r] = x8 ^ a[r];
      mb[r] = x8 ^ x2 ^ a[r];
      md[r] = x8 ^ x4 ^ a[r];
      me[r] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    w_next_buf = r_buf;
    w_idx      = 2'd0;
    for (int j = 0; j < COLS_PER_CYCLE; j++) begin
      w_idx = r_cnt + 2'(j);
      w_next_buf[127 - 32*int'(w_idx) -: 32] = inv_mix_col(r_buf[127 - 32*int'(w_idx) -: 32]);
    end
  end

  assign w_last    = (r_cnt == LAST_CNT);
  assign out_valid = (r_state == S_DONE);
  assign in_ready  = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
  assign w_accept  = in_valid && in_ready;
  assign state_out = r_buf;

  // NOTE: state is updated with non-blocking assignments only; the buffer is reset
  // as well because it drives state_out directly and must read zero after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 2'd0;
      r_buf   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_buf   <= state_in;
            r_cnt   <= 2'd0;
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          r_buf <= w_next_buf;
          r_cnt <= r_cnt + CNT_STEP;
          if (w_last) r_state <= S_DONE;
        end
        S_DONE: begin
          if (w_accept) begin
            r_buf   <= state_in;
            r_cnt   <= 2'd0;
            r_state <= S_BUSY;
          end else if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/inv_mix_columns_seq.md
Name: inv_mix_columns_seq

Overview:
Column-serial AES InvMixColumns engine for the decryption datapath. It takes a full 128-bit state via a valid/ready handshake and multiplies each 32-bit column by the inverse MixColumns matrix {0e,0b,0d,09} over GF(2^8) with polynomial 0x11b. It processes COLS_PER_CYCLE columns per clock and then presents the result on an output valid/ready handshake. It sits between InvSubBytes/AddRoundKey and the next inverse round, and is the decrypt-side counterpart of the single-column MixColumns logic.

Parameters:
COLS_PER_CYCLE, 1, columns transformed per clock; legal values 1, 2, 4; any other value is an elaboration error.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
in_valid  input  1  state_in is valid
in_ready  output  1  block can accept a state
state_in  input  128  input state; column c at [127-32c -: 32]; within a column, row 0 at [31:24] down to row 3 at [7:0]
out_valid  output  1  state_out is valid
out_ready  input  1  downstream accepts state_out
state_out  output  128  InvMixColumns result, same packing as state_in

Behaviour:
- Reset (synchronous, rst=1 at an edge) has priority over everything:
  - state goes to IDLE, column counter = 0, out_valid = 0, state_out = 0.
  - in_ready is 1 in the cycle after reset.
  - A transfer in progress at reset is discarded and produces no output.
- Per column, with input bytes a0..a3 and xtime(x) = (x<<1) ^ (x[7] ? 8'h1b : 0):
  - b0 = 0e·a0 ^ 0b·a1 ^ 0d·a2 ^ 09·a3, and b1..b3 are the row rotations of the same matrix.
  - The multipliers are built from chained xtime: 2x, 4x, 8x, then 09 = 8^1, 0b = 8^2^1, 0d = 8^4^1, 0e = 8^4^2.
  - All arithmetic is 8-bit XOR only; there are no carries.
- States:
  - IDLE: in_ready = 1, out_valid = 0. On in_valid & in_ready, register state_in into the working buffer, clear the counter, go to BUSY.
  - BUSY: in_ready = 0. Each cycle, transform columns cnt .. cnt+COLS_PER_CYCLE-1 in place and advance cnt by COLS_PER_CYCLE. When the last column is written, go to DONE.
  - DONE: out_valid = 1. state_out equals the buffer and stays stable while out_valid=1 & out_ready=0. On out_ready, go to IDLE unless a new input is accepted in the same cycle.
- Latency:
  - Accept edge T; BUSY occupies edges T+1 .. T+4/COLS_PER_CYCLE; out_valid is first high after edge T+4/COLS_PER_CYCLE.
  - With COLS_PER_CYCLE=1, out_valid is high 4 cycles after acceptance.
- Back-to-back: in DONE, in_ready = out_ready. A simultaneous output handshake and in_valid completes the output and captures the new state in the same edge, then goes straight to BUSY.
- in_valid in BUSY is ignored. Upstream must hold the data until in_ready; no data is lost.
- Column counter wraps at 4: 2 bits, advancing by COLS_PER_CYCLE modulo 4.
- Before the first completed operation, state_out = 0.
- state_out is driven straight from the buffer register; there is no combinational path from state_in to any output.

Test Plan:
- Single column, COLS_PER_CYCLE=1: state_in column 0 = 8e4da1bc, other columns 01010101 -> state_out column 0 = db135345, others 01010101; out_valid rises exactly 4 cycles after acceptance.
- Full state, COLS_PER_CYCLE=1: columns 8e4da1bc, 9fdc589d, d5d5d7d6, 4d7ebdf8 -> db135345, f20a225c, d4d4d4d5, 2d26314c. Also invert FIPS-197 Appendix B round-1 MixColumns output and compare with its pre-MixColumns state.
- Same vectors with COLS_PER_CYCLE=2 and 4 -> identical results; latency 2 and 1 cycles respectively.
- Backpressure: hold out_ready=0 for 10 cycles -> out_valid stays 1, state_out stable, in_ready=0. Then assert out_ready with in_valid=1 -> both handshakes occur on the same edge, and the second result follows after 4 more cycles.
- rst asserted mid-BUSY (cycle 2 of 4) -> next cycle out_valid=0, state_out=0, in_ready=1; a fresh input then completes correctly.
- Round trip: random 128-bit X driven through the existing MixColumns per column and then this block -> output equals X for 1000 random vectors.
